// File: rtl/core_mem_bridge_pkg.sv
// Shared types and helpers for the core/BRAM bridge.
package core_mem_bridge_pkg;

    // Run-control states of the bridge.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_FFF0;

    // True when a byte address falls inside a BRAM of 2^addr_w words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/core_mem_bridge.sv
// Bridge between the RV32I core and an external simple-dual-port BRAM.
// Owns the core's raddr register and reset, gives the host load/readback
// access while the core is held in reset, and ends a run on a tohost store
// or when the RUN-cycle limit is reached.
module core_mem_bridge
    import core_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
    parameter int unsigned MAX_CYCLES  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic [31:0]       tohost,
    output logic [31:0]       cycle_cnt,
    input  logic              h_cmd_valid,
    output logic              h_cmd_ready,
    input  logic              h_cmd_we,
    input  logic [31:0]       h_cmd_addr,
    input  logic [31:0]       h_cmd_wdata,
    output logic              h_rsp_valid,
    output logic [31:0]       h_rsp_rdata,
    output logic              core_rst_n,
    output logic [31:0]       core_raddr,
    output logic [31:0]       core_mem_data,
    input  logic [31:0]       core_raddr_next,
    input  logic [31:0]       core_waddr,
    input  logic [31:0]       core_wdata,
    input  logic              core_wen,
    output logic [ADDR_W-1:0] bram_addr_a,
    input  logic [31:0]       bram_rdata_a,
    output logic              bram_we_b,
    output logic [ADDR_W-1:0] bram_addr_b,
    output logic [31:0]       bram_wdata_b
);

    state_e      state_q, state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        rsp_valid_q, rsp_is_wr_q;
    logic        rd_oor_q, rd_oor_d;
    logic        byp_q, byp_d;
    logic [31:0] byp_data_q;

    logic        rd_en;
    logic [31:0] rd_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        host_acc;
    logic [31:0] rd_word;

    assign busy        = (state_q == StPrime) || (state_q == StRun);
    assign halted      = (state_q == StDone);
    assign core_rst_n  = (state_q == StRun);
    assign h_cmd_ready = ((state_q == StIdle) || (state_q == StDone)) && !start;
    assign host_acc    = h_cmd_ready && h_cmd_valid;

    assign timeout   = timeout_q;
    assign tohost    = tohost_q;
    assign cycle_cnt = cnt_q;
    assign core_raddr = raddr_q;

    assign bram_addr_a  = rd_addr[ADDR_W+1:2];
    assign bram_we_b    = wr_en;
    assign bram_addr_b  = wr_addr[ADDR_W+1:2];
    assign bram_wdata_b = wr_data;

    // BRAM is read-first, so a same-word write last cycle must be forwarded.
    assign rd_word       = rd_oor_q ? 32'd0 : (byp_q ? byp_data_q : bram_rdata_a);
    assign core_mem_data = rd_word;
    assign h_rsp_valid   = rsp_valid_q;
    assign h_rsp_rdata   = rsp_is_wr_q ? 32'd0 : rd_word;

    // Next-state, port A/B selection and run bookkeeping.
    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        tohost_d  = tohost_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        rd_en     = 1'b0;
        rd_addr   = 32'd0;
        wr_en     = 1'b0;
        wr_addr   = 32'd0;
        wr_data   = 32'd0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StPrime;
                    cnt_d     = 32'd0;
                    timeout_d = 1'b0;
                end else if (h_cmd_valid) begin
                    if (h_cmd_we) begin
                        wr_en   = addr_in_range(h_cmd_addr, ADDR_W);
                        wr_addr = h_cmd_addr;
                        wr_data = h_cmd_wdata;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = h_cmd_addr;
                    end
                end
            end
            StPrime: begin
                rd_en   = 1'b1;
                rd_addr = RESET_PC;
                raddr_d = RESET_PC;
                state_d = StRun;
            end
            StRun: begin
                rd_en   = 1'b1;
                rd_addr = core_raddr_next;
                raddr_d = core_raddr_next;
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (core_wen && (core_waddr == TOHOST_ADDR)) begin
                    // A tohost store wins over a coincident timeout.
                    tohost_d = core_wdata;
                    state_d  = StDone;
                end else begin
                    if (core_wen) begin
                        wr_en   = addr_in_range(core_waddr, ADDR_W);
                        wr_addr = core_waddr;
                        wr_data = core_wdata;
                    end
                    if ((MAX_CYCLES != 0) && (cnt_q == MAX_CYCLES - 1)) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        rd_oor_d = rd_en && !addr_in_range(rd_addr, ADDR_W);
        byp_d    = rd_en && wr_en && (wr_addr[ADDR_W+1:2] == rd_addr[ADDR_W+1:2]);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            raddr_q     <= RESET_PC;
            tohost_q    <= 32'd0;
            cnt_q       <= 32'd0;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_is_wr_q <= 1'b0;
            rd_oor_q    <= 1'b0;
            byp_q       <= 1'b0;
            byp_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            tohost_q    <= tohost_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            rsp_valid_q <= host_acc;
            rsp_is_wr_q <= host_acc && h_cmd_we;
            rd_oor_q    <= rd_oor_d;
            byp_q       <= byp_d;
            byp_data_q  <= wr_data;
        end
    end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Bench for core_mem_bridge: plays the host and the core, models the BRAM,
// and predicts read data from a plain word-array view of memory.
module tb_core_mem_bridge;

    localparam int unsigned AW     = 14;
    localparam logic [31:0] TOHOST = 32'h0000_FFF0;
    localparam int unsigned LIMIT  = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, halted, timeout;
    logic [31:0]   tohost, cycle_cnt;
    logic          h_cmd_valid, h_cmd_ready, h_cmd_we;
    logic [31:0]   h_cmd_addr, h_cmd_wdata;
    logic          h_rsp_valid;
    logic [31:0]   h_rsp_rdata;
    logic          core_rst_n;
    logic [31:0]   core_raddr, core_mem_data;
    logic [31:0]   core_raddr_next, core_waddr, core_wdata;
    logic          core_wen;
    logic [AW-1:0] bram_addr_a, bram_addr_b;
    logic [31:0]   bram_rdata_a, bram_wdata_b;
    logic          bram_we_b;

    logic [31:0] bram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    core_mem_bridge #(
        .ADDR_W      (AW),
        .RESET_PC    (32'h0),
        .TOHOST_ADDR (TOHOST),
        .MAX_CYCLES  (LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .busy            (busy),
        .halted          (halted),
        .timeout         (timeout),
        .tohost          (tohost),
        .cycle_cnt       (cycle_cnt),
        .h_cmd_valid     (h_cmd_valid),
        .h_cmd_ready     (h_cmd_ready),
        .h_cmd_we        (h_cmd_we),
        .h_cmd_addr      (h_cmd_addr),
        .h_cmd_wdata     (h_cmd_wdata),
        .h_rsp_valid     (h_rsp_valid),
        .h_rsp_rdata     (h_rsp_rdata),
        .core_rst_n      (core_rst_n),
        .core_raddr      (core_raddr),
        .core_mem_data   (core_mem_data),
        .core_raddr_next (core_raddr_next),
        .core_waddr      (core_waddr),
        .core_wdata      (core_wdata),
        .core_wen        (core_wen),
        .bram_addr_a     (bram_addr_a),
        .bram_rdata_a    (bram_rdata_a),
        .bram_we_b       (bram_we_b),
        .bram_addr_b     (bram_addr_b),
        .bram_wdata_b    (bram_wdata_b)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with one-cycle read latency.
    always @(posedge clk) begin
        bram_rdata_a <= bram[bram_addr_a];
        if (bram_we_b) bram[bram_addr_b] <= bram_wdata_b;
    end

    function automatic logic is_oor(input logic [31:0] addr);
        return addr >= (32'd1 << (AW + 2));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host command; returns what the response port showed one cycle later.
    task automatic host_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic v, output logic [31:0] rd);
        h_cmd_valid = 1'b1;
        h_cmd_we    = we;
        h_cmd_addr  = addr;
        h_cmd_wdata = wdata;
        tick();
        v  = h_rsp_valid;
        rd = h_rsp_rdata;
        h_cmd_valid = 1'b0;
        h_cmd_we    = 1'b0;
        if (we && !is_oor(addr)) ref_mem[int'(addr >> 2)] = wdata;
    endtask

    task automatic clear_core();
        core_wen        = 1'b0;
        core_waddr      = 32'd0;
        core_wdata      = 32'd0;
        core_raddr_next = 32'd0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%h want=0", halted); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%h want=0", timeout); end
        total++; if (tohost !== 32'd0) begin bad++; $display("FAIL reset_tohost got=%h want=0", tohost); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", cycle_cnt); end
        total++; if (h_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h want=0", h_rsp_valid); end
        total++; if (core_rst_n !== 1'b0) begin bad++; $display("FAIL reset_core_rst got=%h want=0", core_rst_n); end
        total++; if (core_raddr !== 32'd0) begin bad++; $display("FAIL reset_raddr got=%h want=0", core_raddr); end
        total++; if (h_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%h want=1", h_cmd_ready); end
    endtask

    task automatic test_host_load();
        logic v; logic [31:0] rd;
        host_op(1'b1, 32'h0, 32'h0050_0093, v, rd);
        total++; if (v !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL hw0_rsp got=%h/%h want=1/0", v, rd); end
        host_op(1'b1, 32'h4, 32'h0010_0073, v, rd);
        total++; if (v !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL hw1_rsp got=%h/%h want=1/0", v, rd); end
        host_op(1'b0, 32'h4, 32'h0, v, rd);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL hr_valid got=%h want=1", v); end
        total++; if (rd !== 32'h0010_0073) begin bad++; $display("FAIL hr_data got=%h want=00100073", rd); end
        tick();
        total++; if (h_rsp_valid !== 1'b0) begin bad++; $display("FAIL hr_pulse got=%h want=0", h_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic v; logic [31:0] rd;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        host_op(1'b1, 32'h20, a, v, rd);
        host_op(1'b1, 32'h24, b, v, rd);
        h_cmd_valid = 1'b1; h_cmd_we = 1'b0; h_cmd_addr = 32'h20;
        tick();
        total++; if (h_rsp_valid !== 1'b1 || h_rsp_rdata !== ref_mem[8]) begin
            bad++; $display("FAIL b2b_first got=%h/%h want=1/%h", h_rsp_valid, h_rsp_rdata, ref_mem[8]);
        end
        h_cmd_addr = 32'h24;
        tick();
        total++; if (h_rsp_valid !== 1'b1 || h_rsp_rdata !== ref_mem[9]) begin
            bad++; $display("FAIL b2b_second got=%h/%h want=1/%h", h_rsp_valid, h_rsp_rdata, ref_mem[9]);
        end
        h_cmd_valid = 1'b0;
        tick();
        total++; if (h_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%h want=0", h_rsp_valid); end
    endtask

    task automatic test_tohost();
        start = 1'b1;
        #1;
        total++; if (h_cmd_ready !== 1'b0) begin bad++; $display("FAIL start_blocks_ready got=%h want=0", h_cmd_ready); end
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1 || core_rst_n !== 1'b0) begin
            bad++; $display("FAIL prime_state got=%h/%h want=1/0", busy, core_rst_n);
        end
        tick();
        total++; if (core_rst_n !== 1'b1) begin bad++; $display("FAIL run_core_rst got=%h want=1", core_rst_n); end
        total++; if (core_raddr !== 32'h0 || core_mem_data !== ref_mem[0]) begin
            bad++; $display("FAIL run_c1 got=%h/%h want=0/%h", core_raddr, core_mem_data, ref_mem[0]);
        end
        core_raddr_next = 32'h4;
        tick();
        total++; if (core_raddr !== 32'h4 || core_mem_data !== ref_mem[1]) begin
            bad++; $display("FAIL run_c2 got=%h/%h want=4/%h", core_raddr, core_mem_data, ref_mem[1]);
        end
        core_raddr_next = 32'h8; core_wen = 1'b1; core_waddr = TOHOST; core_wdata = 32'd5;
        #1;
        total++; if (bram_we_b !== 1'b0) begin bad++; $display("FAIL tohost_no_we got=%h want=0", bram_we_b); end
        tick();
        clear_core();
        total++; if (halted !== 1'b1 || core_rst_n !== 1'b0) begin
            bad++; $display("FAIL tohost_done got=%h/%h want=1/0", halted, core_rst_n);
        end
        total++; if (tohost !== 32'd5) begin bad++; $display("FAIL tohost_val got=%h want=5", tohost); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tohost_timeout got=%h want=0", timeout); end
        total++; if (cycle_cnt !== 32'd2) begin bad++; $display("FAIL tohost_cnt got=%h want=2", cycle_cnt); end
    endtask

    task automatic test_timeout();
        logic v; logic [31:0] rd;
        int runs;
        host_op(1'b1, 32'h0, 32'h0000_006F, v, rd);
        start = 1'b1; tick(); start = 1'b0; tick();
        runs = 0;
        while (!halted && runs < 40) begin
            runs++;
            total++; if (core_mem_data !== 32'h0000_006F) begin
                bad++; $display("FAIL loop_fetch got=%h want=0000006f", core_mem_data);
            end
            core_raddr_next = 32'h0;
            tick();
        end
        total++; if (runs != int'(LIMIT)) begin bad++; $display("FAIL loop_runs got=%0d want=%0d", runs, LIMIT); end
        total++; if (cycle_cnt !== LIMIT) begin bad++; $display("FAIL loop_cnt got=%0d want=%0d", cycle_cnt, LIMIT); end
        total++; if (timeout !== 1'b1 || halted !== 1'b1) begin
            bad++; $display("FAIL loop_timeout got=%h/%h want=1/1", timeout, halted);
        end
    endtask

    task automatic test_bypass_oor();
        logic v; logic [31:0] rd;
        host_op(1'b1, 32'h100, 32'h1111_1111, v, rd);
        start = 1'b1; tick(); start = 1'b0; tick();
        core_wen = 1'b1; core_waddr = 32'h100; core_wdata = 32'hDEAD_BEEF; core_raddr_next = 32'h100;
        ref_mem[64] = 32'hDEAD_BEEF;
        #1;
        total++; if (bram_we_b !== 1'b1) begin bad++; $display("FAIL byp_we got=%h want=1", bram_we_b); end
        tick();
        total++; if (core_mem_data !== 32'hDEAD_BEEF || core_raddr !== 32'h100) begin
            bad++; $display("FAIL byp_data got=%h/%h want=deadbeef/100", core_mem_data, core_raddr);
        end
        core_waddr = 32'h0004_0000; core_wdata = 32'hBAD0_BAD0; core_raddr_next = 32'h0004_0000;
        #1;
        total++; if (bram_we_b !== 1'b0) begin bad++; $display("FAIL oor_we got=%h want=0", bram_we_b); end
        tick();
        total++; if (core_mem_data !== 32'd0) begin bad++; $display("FAIL oor_fetch got=%h want=0", core_mem_data); end
        core_waddr = TOHOST; core_wdata = 32'h0000_1234; core_raddr_next = 32'h0;
        tick();
        clear_core();
        total++; if (halted !== 1'b1 || tohost !== 32'h1234) begin
            bad++; $display("FAIL byp_done got=%h/%h want=1/1234", halted, tohost);
        end
        host_op(1'b0, 32'h100, 32'h0, v, rd);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_readback got=%h want=deadbeef", rd); end
        host_op(1'b0, 32'h0, 32'h0, v, rd);
        total++; if (rd !== ref_mem[0]) begin bad++; $display("FAIL oor_alias got=%h want=%h", rd, ref_mem[0]); end
        h_cmd_valid = 1'b1; h_cmd_we = 1'b1; h_cmd_addr = 32'h0004_0000; h_cmd_wdata = 32'h5555_5555;
        #1;
        total++; if (bram_we_b !== 1'b0) begin bad++; $display("FAIL host_oor_we got=%h want=0", bram_we_b); end
        tick();
        h_cmd_valid = 1'b0; h_cmd_we = 1'b0;
        host_op(1'b0, 32'h0004_0000, 32'h0, v, rd);
        total++; if (v !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL host_oor_rd got=%h/%h want=1/0", v, rd); end
    endtask

    task automatic test_random_run();
        logic v; logic [31:0] rd;
        logic [31:0] exp_data, exp_raddr, rn, wa;
        int runs;
        for (int i = 0; i < 16; i++) host_op(1'b1, 32'(i) << 2, $urandom, v, rd);
        start = 1'b1; tick(); start = 1'b0; tick();
        exp_data = ref_mem[0];
        exp_raddr = 32'h0;
        runs = 0;
        while (!halted && runs < 40) begin
            runs++;
            total++; if (core_mem_data !== exp_data) begin
                bad++; $display("FAIL rand_rdata got=%h want=%h", core_mem_data, exp_data);
            end
            total++; if (core_raddr !== exp_raddr) begin
                bad++; $display("FAIL rand_raddr got=%h want=%h", core_raddr, exp_raddr);
            end
            rn = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 4) == 0) rn = rn + 32'h0004_0000;
            wa = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) wa = wa + 32'h0004_0000;
            core_raddr_next = rn;
            core_wen        = 1'($urandom_range(0, 1));
            core_waddr      = wa;
            core_wdata      = $urandom;
            if (core_wen && !is_oor(wa)) ref_mem[int'(wa >> 2)] = core_wdata;
            exp_data  = is_oor(rn) ? 32'd0 : ref_mem[int'(rn >> 2)];
            exp_raddr = rn;
            tick();
        end
        clear_core();
        total++; if (runs != int'(LIMIT) || timeout !== 1'b1) begin
            bad++; $display("FAIL rand_end got=%0d/%h want=%0d/1", runs, timeout, LIMIT);
        end
        for (int i = 0; i < 16; i++) begin
            host_op(1'b0, 32'(i) << 2, 32'h0, v, rd);
            total++; if (rd !== ref_mem[i]) begin
                bad++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, rd, ref_mem[i]);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        start = 1'b1; tick(); start = 1'b0; tick();
        core_raddr_next = 32'h8;
        tick();
        rst_n = 1'b0;
        tick();
        clear_core();
        total++; if (busy !== 1'b0 || halted !== 1'b0 || core_rst_n !== 1'b0) begin
            bad++; $display("FAIL mrst_state got=%h/%h/%h want=0/0/0", busy, halted, core_rst_n);
        end
        total++; if (core_raddr !== 32'h0) begin bad++; $display("FAIL mrst_raddr got=%h want=0", core_raddr); end
        total++; if (tohost !== 32'd0) begin bad++; $display("FAIL mrst_tohost got=%h want=0", tohost); end
        total++; if (cycle_cnt !== 32'd0) begin bad++; $display("FAIL mrst_cnt got=%h want=0", cycle_cnt); end
        rst_n = 1'b1;
        tick();
        total++; if (h_cmd_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%h want=1", h_cmd_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        h_cmd_valid = 1'b0; h_cmd_we = 1'b0; h_cmd_addr = 32'd0; h_cmd_wdata = 32'd0;
        clear_core();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_host_load();
        test_back_to_back();
        test_tohost();
        test_timeout();
        test_bypass_oor();
        for (int r = 0; r < 3; r++) test_random_run();
        test_mid_run_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
